// File: rtl/minimips_pkg.sv
// Shared MiniMIPS definitions: logic-unit opcodes, checker state encodings and default width.
package minimips_pkg;

    localparam int MM_WIDTH = 32;

    typedef enum logic [1:0] {
        LOGIC_OP_AND = 2'b00,
        LOGIC_OP_OR  = 2'b01,
        LOGIC_OP_XOR = 2'b10,
        LOGIC_OP_NOR = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'b00,
        CHK_RUN   = 2'b01,
        CHK_DRAIN = 2'b10,
        CHK_DONE  = 2'b11
    } chk_state_e;

endpackage

// File: rtl/logic_ref_model.sv
// Combinational reference for the MiniMIPS bitwise logic units: (op, a, b) -> expected result.
import minimips_pkg::*;

module logic_ref_model #(
    parameter int WIDTH = MM_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        expected = '0;
        case (op)
            LOGIC_OP_AND: expected = a & b;
            LOGIC_OP_OR:  expected = a | b;
            LOGIC_OP_XOR: expected = a ^ b;
            LOGIC_OP_NOR: expected = ~(a | b);
            default:      expected = '0;
        endcase
    end

endmodule

// File: rtl/logic_result_checker.sv
// Response checker for the MiniMIPS logic units: one-deep stage, saturating pass/fail counters, first-fail capture.
// Optional STOP_ON_FAIL_EN: the first mismatch forces DONE and discards any transfer accepted alongside it.
//
// state | meaning
// IDLE  | after reset, not accepting
// RUN   | accepting triples, checking stage
// DRAIN | stop seen, last staged triple being checked
// DONE  | finished, stats held until next start
import minimips_pkg::*;

module logic_result_checker #(
    parameter int WIDTH = MM_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_r,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_seen,
    output logic [CNT_W-1:0] fail_index,
    output logic [WIDTH-1:0] fail_expected,
    output logic [WIDTH-1:0] fail_actual,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    chk_state_e       state, state_nxt;
    logic             stage_valid;
    logic [1:0]       stage_op;
    logic [WIDTH-1:0] stage_a, stage_b, stage_r;
    logic [CNT_W-1:0] stage_idx, txn_idx;
    logic [WIDTH-1:0] expected;
    logic             xfer, load, clear, mismatch, first_fail;

    logic_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op       (stage_op),
        .a        (stage_a),
        .b        (stage_b),
        .expected (expected)
    );

    assign in_ready   = (state == CHK_RUN);
    assign done       = (state == CHK_DONE);
    assign xfer       = in_valid & in_ready;
    assign mismatch   = stage_valid && (expected != stage_r);
    assign first_fail = mismatch && !fail_seen;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        load      = xfer;
`ifdef STOP_ON_FAIL_EN
        if (first_fail && (state == CHK_RUN || state == CHK_DRAIN)) begin
            load = 1'b0;
        end
`endif
        case (state)
            CHK_IDLE, CHK_DONE: begin
                if (start) begin
                    state_nxt = CHK_RUN;
                    clear     = 1'b1;
                end
            end
            CHK_RUN: begin
                if (stop) state_nxt = CHK_DRAIN;
            end
            CHK_DRAIN: begin
                // nothing loads in DRAIN, so the stage is empty after this edge
                if (!load) state_nxt = CHK_DONE;
            end
            default: state_nxt = CHK_IDLE;
        endcase
`ifdef STOP_ON_FAIL_EN
        if (first_fail && (state == CHK_RUN || state == CHK_DRAIN)) begin
            state_nxt = CHK_DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CHK_IDLE;
            stage_valid   <= 1'b0;
            stage_op      <= '0;
            stage_a       <= '0;
            stage_b       <= '0;
            stage_r       <= '0;
            stage_idx     <= '0;
            txn_idx       <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            fail_seen     <= 1'b0;
            fail_index    <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else begin
            state       <= state_nxt;
            stage_valid <= load;
            if (load) begin
                stage_op  <= in_op;
                stage_a   <= in_a;
                stage_b   <= in_b;
                stage_r   <= in_r;
                stage_idx <= txn_idx;
                txn_idx   <= txn_idx + CNT_ONE;
            end
            if (clear) begin
                txn_idx       <= '0;
                pass_count    <= '0;
                fail_count    <= '0;
                fail_seen     <= 1'b0;
                fail_index    <= '0;
                fail_expected <= '0;
                fail_actual   <= '0;
            end else if (stage_valid) begin
                if (mismatch) begin
                    if (fail_count != '1) fail_count <= fail_count + CNT_ONE;
                    if (!fail_seen) begin
                        fail_seen     <= 1'b1;
                        fail_index    <= stage_idx;
                        fail_expected <= expected;
                        fail_actual   <= stage_r;
                    end
                end else if (pass_count != '1) begin
                    pass_count <= pass_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed self-checking bench for logic_result_checker (4-bit counters so saturation is reachable).
// Build with STOP_ON_FAIL_EN defined to exercise the stop-on-first-fail variant.
module tb_logic_result_checker;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, start, stop, in_valid, in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b, in_r;
    logic [CW-1:0] pass_count, fail_count, fail_index;
    logic          fail_seen, done;
    logic [W-1:0]  fail_expected, fail_actual;

    int checks = 0;
    int fails  = 0;

    logic_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_r          (in_r),
        .pass_count    (pass_count),
        .fail_count    (fail_count),
        .fail_seen     (fail_seen),
        .fail_index    (fail_index),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
        in_op = op;
        in_a  = a;
        in_b  = b;
        in_r  = r;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r);
        drive(op, a, b, r);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic restart();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        drive(2'b01, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;

        // idle with in_valid asserted: nothing accepted
        drive(2'b01, 32'h1, 32'h2, 32'h3);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("idle_in_ready", in_ready, 0);
        check("idle_pass", pass_count, 0);
        check("idle_fail", fail_count, 0);
        check("idle_fail_seen", fail_seen, 0);
        check("idle_fail_index", fail_index, 0);
        check("idle_fail_expected", fail_expected, 0);
        check("idle_fail_actual", fail_actual, 0);
        check("idle_done", done, 0);

        // two passing ORs
        start = 1'b1; tick(); start = 1'b0;
        check("run_in_ready", in_ready, 1);
        send(2'b01, 32'hFFFFFFFF, 32'h40A00400, 32'hFFFFFFFF);
        send(2'b01, 32'h22220225, 32'hC2420423, 32'hE2620627);
        tick();
        check("or_pass", pass_count, 2);
        check("or_fail", fail_count, 0);

        // first mismatch on txn 1
        restart();
        send(2'b01, 32'h22220225, 32'hC2420423, 32'hE2620627);
        send(2'b01, 32'h22220225, 32'hC2420423, 32'hE2620626);
`ifdef STOP_ON_FAIL_EN
        send(2'b01, 32'h1, 32'h2, 32'h3);
        check("sof_done", done, 1);
        check("sof_in_ready", in_ready, 0);
        tick();
        check("sof_discard_pass", pass_count, 1);
`else
        tick();
`endif
        check("cap_fail_seen", fail_seen, 1);
        check("cap_fail_index", fail_index, 1);
        check("cap_fail_expected", fail_expected, 32'hE2620627);
        check("cap_fail_actual", fail_actual, 32'hE2620626);
        check("cap_fail_count", fail_count, 1);
        check("cap_pass_count", pass_count, 1);
`ifndef STOP_ON_FAIL_EN
        send(2'b00, 32'hFFFFFFFF, 32'h0, 32'h1);
        tick();
        check("fail2_count", fail_count, 2);
        check("fail2_index", fail_index, 1);
        check("fail2_expected", fail_expected, 32'hE2620627);
        check("fail2_actual", fail_actual, 32'hE2620626);
`endif

        // XOR / NOR / AND passes back to back
        restart();
        send(2'b10, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A);
        send(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF);
        send(2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
`ifndef STOP_ON_FAIL_EN
        send(2'b01, 32'h1, 32'h2, 32'h0);
`endif
        tick();
        check("mix_pass", pass_count, 3);
`ifndef STOP_ON_FAIL_EN
        check("mix_fail", fail_count, 1);
        check("mix_fail_index", fail_index, 3);
`endif

        // start in RUN is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_run_ready", in_ready, 1);
        check("start_in_run_pass", pass_count, 3);

        // start+stop with a transfer: stop wins, transfer counted
        drive(2'b11, 32'h1, 32'h2, 32'hFFFFFFFC);
        in_valid = 1'b1; start = 1'b1; stop = 1'b1;
        tick();
        in_valid = 1'b0; start = 1'b0; stop = 1'b0;
        check("drain_in_ready", in_ready, 0);
        check("drain_done", done, 0);
        tick();
        check("stop_done", done, 1);
        check("stop_pass", pass_count, 4);
        check("stop_in_ready", in_ready, 0);

        // start from DONE clears stats
        start = 1'b1; tick(); start = 1'b0;
        check("clr_pass", pass_count, 0);
        check("clr_fail", fail_count, 0);
        check("clr_fail_seen", fail_seen, 0);
        check("clr_fail_index", fail_index, 0);
        check("clr_fail_expected", fail_expected, 0);
        check("clr_fail_actual", fail_actual, 0);
        check("clr_done", done, 0);
        check("clr_in_ready", in_ready, 1);

        // reset the cycle after a transfer discards the stage
        send(2'b01, 32'h1, 32'h2, 32'h3);
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        check("rst_in_ready", in_ready, 0);

        // saturation: 17 passes then a fail at txn 17 (index wraps to 1)
        start = 1'b1; tick(); start = 1'b0;
        drive(2'b00, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000);
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        in_valid = 1'b0;
        send(2'b00, 32'hFFFF0000, 32'h00FF00FF, 32'h00000000);
        tick();
        check("sat_pass", pass_count, 4'hF);
        check("sat_fail", fail_count, 1);
        check("sat_fail_index", fail_index, 1);
        check("sat_fail_expected", fail_expected, 32'h00FF0000);
`ifndef STOP_ON_FAIL_EN
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        tick();
        check("sat_fail_count", fail_count, 4'hF);
        check("sat_pass_hold", pass_count, 4'hF);
`else
        check("sat_sof_done", done, 1);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
